// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder step per clock, result and carry registered at FIN.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output OVF.
`timescale 1ns/1ps
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             sum_bit, carry_next;
    logic [WIDTH-1:0] sum_next;

    always_comb begin
        sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        sum_next            = sum_q >> 1;
        sum_next[WIDTH-1]   = sum_bit;
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_q != IDLE);
        DONE = (state_q == FIN);
    end

    // The last SHIFT step writes S/Cout directly so they are valid while in FIN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            S       <= '0;
            Cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            OVF     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Cin;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_next;
                    sum_q   <= sum_next;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        S    <= sum_next;
                        Cout <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
                        OVF  <= carry_q ^ carry_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: cycle-level reference model plus directed literal cases.
`timescale 1ns/1ps
module tb_serial_adder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] s;

    logic       start1, cin1;
    logic [0:0] a1, b1, s1;
    logic       busy1, done1, cout1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf, ovf1;
`endif

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .START(start), .A(a), .B(b), .Cin(cin),
        .BUSY(busy), .DONE(done), .S(s), .Cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .OVF(ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1), .Cin(cin1),
        .BUSY(busy1), .DONE(done1), .S(s1), .Cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .OVF(ovf1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: tracks edges since accept; result is A+B+Cin, visible W edges later.
    int         m_cnt = -1;
    bit         live = 0;
    logic [8:0] m_pend;
    logic [7:0] m_s;
    logic       m_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic       m_pend_ovf, m_ovf;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = -1;
            m_s   = '0;
            m_c   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            m_ovf = 1'b0;
`endif
            live  = 1;
        end else if (m_cnt < 0) begin
            if (start) begin
                m_pend = {1'b0, a} + {1'b0, b} + 9'(cin);
`ifdef SERIAL_ADDER_OVF_EN
                m_pend_ovf = (a[7] == b[7]) && (m_pend[7] != a[7]);
`endif
                m_cnt = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 8) begin
                m_s = m_pend[7:0];
                m_c = m_pend[8];
`ifdef SERIAL_ADDER_OVF_EN
                m_ovf = m_pend_ovf;
`endif
            end else if (m_cnt == 9) begin
                m_cnt = -1;
            end
        end
        #1;
        if (live) begin
            chk("model_busy", 32'(busy), 32'(m_cnt >= 0));
            chk("model_done", 32'(done), 32'(m_cnt == 8));
            chk("model_s",    32'(s),    32'(m_s));
            chk("model_cout", 32'(cout), 32'(m_c));
`ifdef SERIAL_ADDER_OVF_EN
            chk("model_ovf",  32'(ovf),  32'(m_ovf));
`endif
        end
    end

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input bit inj,
                        input logic [7:0] es, input logic ec, input string nm);
        int n, busy_n, dones;
        bit seen;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        n = 1; busy_n = int'(busy); seen = done;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (inj && n == 3) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end else begin
                start = 1'b0;
            end
            busy_n += int'(busy);
            seen = done;
        end
        start = 1'b0;
        chk({nm, "_latency"}, 32'(n), 32'd9);
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'd9);
        chk({nm, "_s"}, 32'(s), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            dones += int'(done);
        end
        chk({nm, "_extra_done"}, 32'(dones), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones, first, second, n;
        logic [1:0] fa;
        bit seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_s", 32'(s), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        run8(8'h00, 8'h00, 1'b1, 0, 8'h01, 1'b0, "zero_cin");
        run8(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, "ff_plus_1");
        run8(8'hA5, 8'h5A, 1'b1, 0, 8'h00, 1'b1, "a5_5a_cin");
`ifdef SERIAL_ADDER_OVF_EN
        run8(8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, "ovf_pos");
        chk("ovf_pos_ovf", 32'(ovf), 32'd1);
        run8(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, "ovf_none");
        chk("ovf_none_ovf", 32'(ovf), 32'd0);
`endif
        run8(8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0, "start_in_shift");

        // Reset during the 4th SHIFT cycle aborts the addition.
        @(negedge clk);
        a = 8'h3C; b = 8'h3C; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        dones = 0;
        repeat (14) begin
            @(negedge clk);
            dones += int'(done);
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run8(8'h3C, 8'hC3, 1'b0, 0, 8'hFF, 1'b0, "after_abort");

        // START held high: back-to-back additions spaced WIDTH+2 cycles apart.
        first = -1; second = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            start = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        end
        start = 1'b0;
        chk("b2b_spacing", 32'(second - first), 32'd10);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) != 0);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        end
        rst = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
            fa = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
            n = 1; seen = done1;
            while (!seen && n < 10) begin
                @(negedge clk);
                n++;
                seen = done1;
            end
            chk($sformatf("w1_latency_%0d", i), 32'(n), 32'd2);
            chk($sformatf("w1_s_%0d", i), 32'(s1), 32'(fa[0]));
            chk($sformatf("w1_cout_%0d", i), 32'(cout1), 32'(fa[1]));
            @(negedge clk);
            chk($sformatf("w1_idle_%0d", i), 32'(busy1), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
